// File: rtl/dir_input_conditioner.sv
// Turns four raw active-low push buttons into debounced levels and a single
// one-hot, one-cycle direction command per press, held off while the engine is busy.
module dir_input_conditioner #(
  parameter int DEB_CYCLES = 250000,
  parameter int CNT_W      = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] botones,
  input  logic       busy,
  input  logic       flush,
  output logic [3:0] dir,
  output logic [3:0] pressed,
  output logic       pending
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PENDING,
    S_LOCKED
  } state_t;

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_pressed;
  logic [3:0]       r_pressed_d;
  logic [CNT_W-1:0] r_cnt [4];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cmd;
  logic [3:0] w_cmd_nxt;
  logic [3:0] r_dir;
  logic [3:0] w_dir_nxt;
  logic       r_pending;
  logic       w_pending_nxt;

  logic [3:0] w_sample;
  logic [3:0] w_rise;
  logic [3:0] w_first;

  // Synchronisers idle at the released (high) level so reset never looks like a press.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values and the chain shifts by exactly one stage per clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= botones;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = ~r_sync2;

  // NOTE: the counter array is reset explicitly; a stale count after reset
  // could let a short glitch toggle a debounced level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      r_pressed   <= '0;
      r_pressed_d <= '0;
    end else begin
      r_pressed_d <= r_pressed;
      for (int i = 0; i < 4; i++) begin
        if (w_sample[i] == r_pressed[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_MAX) begin
          r_pressed[i] <= ~r_pressed[i];
          r_cnt[i]     <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_rise  = r_pressed & ~r_pressed_d;
  // Isolate the lowest set bit: bit0 has highest priority, losers are dropped.
  assign w_first = w_rise & (~w_rise + 4'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cmd     <= '0;
      r_dir     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cmd     <= w_cmd_nxt;
      r_dir     <= w_dir_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cmd_nxt     = r_cmd;
    w_dir_nxt     = '0;
    w_pending_nxt = r_pending;
    case (r_state)
      S_IDLE: begin
        if (|w_rise) begin
          w_cmd_nxt     = w_first;
          w_pending_nxt = 1'b1;
          w_state_nxt   = S_PENDING;
        end
      end
      S_PENDING: begin
        // Flush beats a simultaneous busy fall: the command is discarded.
        if (flush) begin
          w_cmd_nxt     = '0;
          w_pending_nxt = 1'b0;
          w_state_nxt   = S_LOCKED;
        end else if (!busy) begin
          w_dir_nxt     = r_cmd;
          w_cmd_nxt     = '0;
          w_pending_nxt = 1'b0;
          w_state_nxt   = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (r_pressed == 4'b0000) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_cmd_nxt     = '0;
        w_pending_nxt = 1'b0;
      end
    endcase
  end

  assign dir     = r_dir;
  assign pressed = r_pressed;
  assign pending = r_pending;

endmodule

// File: tb/tb_dir_input_conditioner.sv
// Directed bench for dir_input_conditioner with a short debounce window (4 cycles)
// so every latency in the test plan can be checked edge by edge.
module tb_dir_input_conditioner;

  localparam int DEB = 4;
  localparam int CW  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] botones;
  logic       busy;
  logic       flush;
  logic [3:0] dir;
  logic [3:0] pressed;
  logic       pending;

  int errors = 0;
  int checks = 0;

  dir_input_conditioner #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset   (reset),
    .botones (botones),
    .busy    (busy),
    .flush   (flush),
    .dir     (dir),
    .pressed (pressed),
    .pending (pending)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; leaves time 1 unit after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Tick n edges, counting cycles with a non-zero dir and keeping the last value seen.
  task automatic run_count(input int n, output int pulses, output logic [3:0] last);
    pulses = 0;
    last   = '0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (dir !== 4'b0000) begin
        pulses++;
        last = dir;
      end
    end
  endtask

  task automatic release_all();
    botones = 4'b1111;
    busy    = 1'b0;
    flush   = 1'b0;
    tick(15);
  endtask

  task automatic test_reset();
    botones = 4'b1111;
    busy    = 1'b0;
    flush   = 1'b0;
    reset   = 1'b1;
    #12;
    checks++; if (dir !== 4'b0000) begin errors++; $display("FAIL reset_dir got=%b exp=0000", dir); end
    checks++; if (pressed !== 4'b0000) begin errors++; $display("FAIL reset_pressed got=%b exp=0000", pressed); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", pending); end
    #10 reset = 1'b0;
    tick(5);
    checks++; if (pressed !== 4'b0000) begin errors++; $display("FAIL reset_idle_pressed got=%b exp=0000", pressed); end
  endtask

  task automatic test_single_press();
    int p;
    logic [3:0] l;
    botones = 4'b1110;
    tick(5);
    checks++; if (pressed !== 4'b0000) begin errors++; $display("FAIL single_e4_pressed got=%b exp=0000", pressed); end
    tick(1);
    checks++; if (pressed !== 4'b0001) begin errors++; $display("FAIL single_e5_pressed got=%b exp=0001", pressed); end
    tick(1);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL single_e6_pending got=%b exp=1", pending); end
    checks++; if (dir !== 4'b0000) begin errors++; $display("FAIL single_e6_dir got=%b exp=0000", dir); end
    tick(1);
    checks++; if (dir !== 4'b0001) begin errors++; $display("FAIL single_e7_dir got=%b exp=0001", dir); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL single_e7_pending got=%b exp=0", pending); end
    tick(1);
    checks++; if (dir !== 4'b0000) begin errors++; $display("FAIL single_e8_dir got=%b exp=0000", dir); end
    run_count(100, p, l);
    checks++; if (p !== 0) begin errors++; $display("FAIL single_hold_pulses got=%0d exp=0", p); end
    release_all();
    checks++; if (pressed !== 4'b0000) begin errors++; $display("FAIL single_release got=%b exp=0000", pressed); end
  endtask

  task automatic test_bounce();
    int bad_p;
    int bad_d;
    bad_p = 0;
    bad_d = 0;
    for (int k = 0; k < 20; k++) begin
      botones[2] = ((k % 4) < 2) ? 1'b0 : 1'b1;
      tick(1);
      if (pressed !== 4'b0000) bad_p++;
      if (dir !== 4'b0000) bad_d++;
    end
    checks++; if (bad_p !== 0) begin errors++; $display("FAIL bounce_pressed cycles_set=%0d exp=0", bad_p); end
    checks++; if (bad_d !== 0) begin errors++; $display("FAIL bounce_dir cycles_set=%0d exp=0", bad_d); end
    botones = 4'b1011;
    tick(7);
    checks++; if (dir !== 4'b0000) begin errors++; $display("FAIL bounce_e6_dir got=%b exp=0000", dir); end
    tick(1);
    checks++; if (dir !== 4'b0100) begin errors++; $display("FAIL bounce_e7_dir got=%b exp=0100", dir); end
    release_all();
  endtask

  task automatic test_handshake();
    int p;
    logic [3:0] l;
    busy    = 1'b1;
    botones = 4'b1101;
    tick(6);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL hs_e5_pending got=%b exp=0", pending); end
    tick(1);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL hs_e6_pending got=%b exp=1", pending); end
    run_count(13, p, l);
    checks++; if (p !== 0) begin errors++; $display("FAIL hs_busy_pulses got=%0d exp=0", p); end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL hs_e19_pending got=%b exp=1", pending); end
    busy = 1'b0;
    tick(1);
    checks++; if (dir !== 4'b0010) begin errors++; $display("FAIL hs_e20_dir got=%b exp=0010", dir); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL hs_e20_pending got=%b exp=0", pending); end
    tick(1);
    checks++; if (dir !== 4'b0000) begin errors++; $display("FAIL hs_e21_dir got=%b exp=0000", dir); end
    release_all();
  endtask

  task automatic test_simultaneous();
    int p;
    logic [3:0] l;
    botones = 4'b0101;
    run_count(20, p, l);
    checks++; if (p !== 1) begin errors++; $display("FAIL simul_pulses got=%0d exp=1", p); end
    checks++; if (l !== 4'b0010) begin errors++; $display("FAIL simul_dir got=%b exp=0010", l); end
    checks++; if (pressed !== 4'b1010) begin errors++; $display("FAIL simul_pressed got=%b exp=1010", pressed); end
    release_all();
    botones = 4'b0111;
    run_count(20, p, l);
    checks++; if (p !== 1) begin errors++; $display("FAIL simul_b3_pulses got=%0d exp=1", p); end
    checks++; if (l !== 4'b1000) begin errors++; $display("FAIL simul_b3_dir got=%b exp=1000", l); end
    release_all();
  endtask

  task automatic test_flush();
    int p;
    logic [3:0] l;
    busy    = 1'b1;
    botones = 4'b1110;
    tick(8);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL flush_pend_before got=%b exp=1", pending); end
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL flush_pend_after got=%b exp=0", pending); end
    busy = 1'b0;
    run_count(20, p, l);
    checks++; if (p !== 0) begin errors++; $display("FAIL flush_pulses got=%0d exp=0", p); end
    release_all();

    // flush and busy falling on the same edge
    busy    = 1'b1;
    botones = 4'b1110;
    tick(8);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL flush_tie_pend_before got=%b exp=1", pending); end
    flush = 1'b1;
    busy  = 1'b0;
    tick(1);
    flush = 1'b0;
    checks++; if (dir !== 4'b0000) begin errors++; $display("FAIL flush_tie_dir got=%b exp=0000", dir); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL flush_tie_pend_after got=%b exp=0", pending); end
    run_count(10, p, l);
    checks++; if (p !== 0) begin errors++; $display("FAIL flush_tie_pulses got=%0d exp=0", p); end
    release_all();

    // flush in IDLE on the capture edge is ignored
    botones = 4'b1110;
    tick(6);
    checks++; if (pressed !== 4'b0001) begin errors++; $display("FAIL flush_idle_pressed got=%b exp=0001", pressed); end
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL flush_idle_pending got=%b exp=1", pending); end
    tick(1);
    checks++; if (dir !== 4'b0001) begin errors++; $display("FAIL flush_idle_dir got=%b exp=0001", dir); end
    release_all();
  endtask

  task automatic test_async_reset();
    int p;
    logic [3:0] l;
    busy    = 1'b1;
    botones = 4'b1011;
    tick(10);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL arst_pend_before got=%b exp=1", pending); end
    #2 reset = 1'b1;
    #1;
    checks++; if (dir !== 4'b0000) begin errors++; $display("FAIL arst_dir got=%b exp=0000", dir); end
    checks++; if (pressed !== 4'b0000) begin errors++; $display("FAIL arst_pressed got=%b exp=0000", pressed); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL arst_pending got=%b exp=0", pending); end
    busy = 1'b0;
    #3 reset = 1'b0;
    run_count(7, p, l);
    checks++; if (p !== 0) begin errors++; $display("FAIL arst_early_pulses got=%0d exp=0", p); end
    tick(1);
    checks++; if (dir !== 4'b0100) begin errors++; $display("FAIL arst_e7_dir got=%b exp=0100", dir); end
    tick(1);
    checks++; if (dir !== 4'b0000) begin errors++; $display("FAIL arst_e8_dir got=%b exp=0000", dir); end
    release_all();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_handshake();
    test_simultaneous();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dir_input_conditioner.md
Name: dir_input_conditioner

Overview:
- Conditions the four raw, active-low push buttons into clean one-cycle direction commands for the game engine (`juego_neo`).
- Replaces the four independent per-button pulse generators with one block that does:
  - synchronisation and debounce per channel;
  - one-command-per-press arbitration;
  - a ready/busy handshake, so no move is lost or duplicated while the engine is still processing the previous move.
- Sits between the board button pins and the `dir` input of the game engine, in the `clk_25MHz` (game clock) domain.

Parameters:
- DEB_CYCLES, 250000, number of consecutive stable synchronised samples required to change a debounced level (10 ms at 25 MHz).
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  in  1  game clock, 25 MHz.
- reset  in  1  asynchronous, active-high reset.
- botones  in  4  raw buttons, active-low, asynchronous to clk.
- busy  in  1  high while the game engine is processing a move; commands are held while high.
- flush  in  1  synchronous; discards any pending command (driven from restart).
- dir  out  4  one-hot direction pulse, exactly one clk cycle wide; bit i corresponds to botones[i].
- pressed  out  4  debounced button levels, active-high.
- pending  out  1  high while a captured command waits for busy to fall.

Behaviour:
- Reset values, applied asynchronously on reset high:
  - synchroniser flops = 4'b1111 (released);
  - debounce counters = 0;
  - pressed = 0, dir = 0, pending = 0;
  - FSM = IDLE.
- Synchroniser: 2-flop chain per bit; sample s[i] = ~sync2[i].
- Debounce, per channel:
  - If s[i] == pressed[i], the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter == DEB_CYCLES-1 and s[i] still differs, pressed[i] toggles on that edge and the counter clears.
  - A single-cycle glitch shorter than DEB_CYCLES never changes pressed.
- Press event: rise[i] = pressed[i] & ~pressed_d[i], where pressed_d is pressed delayed one cycle.
- FSM states:
  - IDLE:
    - if any rise, capture the lowest-index rising bit into cmd (one-hot), set pending=1, go to PENDING;
    - simultaneous rises are resolved by priority bit0 > bit1 > bit2 > bit3, and the losers are dropped.
  - PENDING:
    - if flush: cmd=0, pending=0, go to LOCKED;
    - else if busy==0: dir <= cmd for one cycle, pending=0, go to LOCKED;
    - else hold.
  - LOCKED:
    - all rise events are ignored;
    - when pressed == 4'b0000, go to IDLE;
    - flush has no further effect here.
- IDLE with flush: flush is ignored, since nothing is pending; a rise in the same cycle is still captured.
- A flush arriving in the same cycle as busy falling wins: no dir pulse is issued.
- dir is registered, zero in all cycles except the single emit cycle, and never has more than one bit set.
- Latency, for busy held low and raw fall sampled at edge t:
  - pressed rises at edge t+DEB_CYCLES+1;
  - FSM enters PENDING at edge t+DEB_CYCLES+2;
  - dir is high for the cycle following edge t+DEB_CYCLES+3.
- Holding a button produces exactly one dir pulse; no auto-repeat.
- A new command requires all buttons to be debounced-released first.
- Reset asserted mid-operation (e.g. while in PENDING): the command is lost and no dir pulse follows reset release.
- Reset deasserted while a button is physically held: after debounce the press registers as a new event.

Test Plan (DEB_CYCLES=4, CNT_W=3):
- Single press: botones=4'b1110 held from before edge 0, busy=0 → pressed[0]=1 after edge 5; dir=4'b0001 for exactly one cycle after edge 7; no further pulse while held 100 cycles.
- Bounce rejection: botones[2] toggled low/high every 2 cycles for 20 cycles → pressed=0 and dir=0 throughout; then held low → one dir=4'b0100 pulse, 7 edges after the last bounce.
- Handshake: busy=1, press botones[1] → pending=1 from edge 6 and dir=0; busy falls at edge 20 → dir=4'b0010 in the cycle after edge 20, pending=0.
- Simultaneous press: botones 1111→0101 on the same cycle → a single dir=4'b0010 pulse; bit3 is dropped; releasing all and pressing botones[3] alone → dir=4'b1000.
- Flush: pending with busy=1, assert flush one cycle → pending=0, no dir pulse after busy falls; next press after full release → normal pulse.
- Async reset: reset pulsed mid-PENDING, not aligned to clk → all outputs 0 immediately; with the button still held, after release of reset one pulse appears DEB_CYCLES+3 edges later.
